// File: rtl/contador_mod_n_barrido.sv
// Modulo-N digit-scan counter: up/down with wrap, synchronous load, active-low one-hot anodes, wrap pulse.
// Optional macro CONTADOR_TICK_INTERNO_EN: an internal PRESCALA-cycle tick replaces the en_i edge detector.
module contador_mod_n_barrido #(
    parameter int N_DIGITOS = 4,
    parameter int ANCHO     = $clog2(N_DIGITOS),
    parameter int PRESCALA  = 10000
) (
    input  logic                 clk_10MHz_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 dir_i,
    input  logic                 load_i,
    input  logic [ANCHO-1:0]     dato_i,
    output logic [ANCHO-1:0]     Q_o,
    output logic [N_DIGITOS-1:0] anodo_o,
    output logic                 tc_o
);

    localparam logic [ANCHO-1:0] L_ULTIMO = ANCHO'(N_DIGITOS - 1);
    localparam logic [ANCHO:0]   L_MODULO = (ANCHO + 1)'(N_DIGITOS);

    if (N_DIGITOS < 2 || N_DIGITOS > 16 || PRESCALA < 2) begin : g_param_invalido
        $error("contador_mod_n_barrido: N_DIGITOS must be 2..16 and PRESCALA >= 2");
    end

    logic w_tick;

`ifdef CONTADOR_TICK_INTERNO_EN
    localparam int AP = $clog2(PRESCALA);
    localparam logic [AP-1:0] L_PRESC_FIN = AP'(PRESCALA - 1);

    logic [AP-1:0] r_presc;
    logic          w_en_unused;

    assign w_en_unused = en_i;
    assign w_tick      = (r_presc == L_PRESC_FIN);

    // Free-running: keeps counting through loads so the scan period stays fixed.
    always_ff @(posedge clk_10MHz_i) begin
        if (!rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + AP'(1);
        end
    end
`else
    logic [1:0] r_registro_en;

    assign w_tick = (r_registro_en == 2'b01);

    always_ff @(posedge clk_10MHz_i) begin
        if (!rst_i) begin
            r_registro_en <= 2'b00;
        end else begin
            r_registro_en <= {r_registro_en[0], en_i};
        end
    end
`endif

    logic [ANCHO-1:0]     r_q;
    logic [N_DIGITOS-1:0] r_anodo;
    logic                 r_tc;
    logic [ANCHO-1:0]     w_q_next;
    logic                 w_tc_next;
    logic [N_DIGITOS-1:0] w_anodo_next;

    // Load wins over a same-cycle tick; that tick is simply dropped.
    always_comb begin
        w_q_next  = r_q;
        w_tc_next = 1'b0;
        if (load_i) begin
            w_q_next = ({1'b0, dato_i} < L_MODULO) ? dato_i : '0;
        end else if (w_tick) begin
            if (dir_i) begin
                if (r_q == L_ULTIMO) begin
                    w_q_next  = '0;
                    w_tc_next = 1'b1;
                end else begin
                    w_q_next = r_q + ANCHO'(1);
                end
            end else begin
                if (r_q == '0) begin
                    w_q_next  = L_ULTIMO;
                    w_tc_next = 1'b1;
                end else begin
                    w_q_next = r_q - ANCHO'(1);
                end
            end
        end
    end

    // Anodes decoded from the next count so they switch on the same edge as Q_o.
    for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_anodo
        assign w_anodo_next[gi] = (w_q_next != ANCHO'(gi));
    end

    always_ff @(posedge clk_10MHz_i) begin
        if (!rst_i) begin
            r_q     <= '0;
            r_anodo <= ~N_DIGITOS'(1);
            r_tc    <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_anodo <= w_anodo_next;
            r_tc    <= w_tc_next;
        end
    end

    assign Q_o     = r_q;
    assign anodo_o = r_anodo;
    assign tc_o    = r_tc;

endmodule

// File: tb/tb_contador_mod_n_barrido.sv
// Directed bench: a 4-digit and a 3-digit scan counter share clock and reset, each with its own controls.
module tb_contador_mod_n_barrido;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic       rst;
    logic       en4, dir4, load4, tc4;
    logic [1:0] dato4, q4;
    logic [3:0] an4;
    logic       en3, dir3, load3, tc3;
    logic [1:0] dato3, q3;
    logic [2:0] an3;

    int n_total = 0;
    int n_bad   = 0;

    contador_mod_n_barrido #(.N_DIGITOS(4), .PRESCALA(5)) u_cnt4 (
        .clk_10MHz_i(clk), .rst_i(rst), .en_i(en4), .dir_i(dir4), .load_i(load4),
        .dato_i(dato4), .Q_o(q4), .anodo_o(an4), .tc_o(tc4)
    );

    contador_mod_n_barrido #(.N_DIGITOS(3), .PRESCALA(5)) u_cnt3 (
        .clk_10MHz_i(clk), .rst_i(rst), .en_i(en3), .dir_i(dir3), .load_i(load3),
        .dato_i(dato3), .Q_o(q3), .anodo_o(an3), .tc_o(tc3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // One en_i pulse: 3 edges high, 5 low; count must move exactly at the second edge.
    task automatic pulse(input bit sel3, input logic [1:0] q_prev, input logic [1:0] q_want,
                         input logic [3:0] an_want, input logic tc_want);
        if (sel3) en3 = 1'b1; else en4 = 1'b1;
        @(negedge clk);
        check_val("pulse_e0_hold", sel3 ? q3 : q4, q_prev);
        @(negedge clk);
        check_val("pulse_q", sel3 ? q3 : q4, q_want);
        check_val("pulse_anodo", sel3 ? {1'b0, an3} : an4, an_want);
        check_val("pulse_tc", sel3 ? tc3 : tc4, tc_want);
        @(negedge clk);
        check_val("pulse_tc_1cyc", sel3 ? tc3 : tc4, 0);
        check_val("pulse_q_stable", sel3 ? q3 : q4, q_want);
        en3 = 1'b0;
        en4 = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    logic [1:0] up_prev [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] up_q    [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] up_an   [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    logic       up_tc   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] dn_prev [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
    logic [1:0] dn_q    [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
    logic [3:0] dn_an   [4] = '{4'b0011, 4'b0101, 4'b0110, 4'b0011};
    logic       dn_tc   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b0;
        en4 = 1'b0; dir4 = 1'b1; load4 = 1'b0; dato4 = 2'd0;
        en3 = 1'b0; dir3 = 1'b0; load3 = 1'b0; dato3 = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_val("rst_q4", q4, 0);
        check_val("rst_an4", an4, 4'b1110);
        check_val("rst_tc4", tc4, 0);
        check_val("rst_an3", an3, 3'b110);
`ifdef CONTADOR_TICK_INTERNO_EN
        dir3 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check_val($sformatf("int_q4_k%0d", k), q4, (k / 5) % 4);
            check_val($sformatf("int_tc4_k%0d", k), tc4, (k == 20) ? 1 : 0);
            check_val($sformatf("int_q3_k%0d", k), q3, (k / 5) % 3);
            check_val($sformatf("int_tc3_k%0d", k), tc3, (k == 15) ? 1 : 0);
        end
`else
        repeat (4) @(negedge clk);
        check_val("idle_q4", q4, 0);
        check_val("idle_an4", an4, 4'b1110);

        for (int i = 0; i < 5; i++) pulse(1'b0, up_prev[i], up_q[i], up_an[i], up_tc[i]);
        for (int i = 0; i < 4; i++) pulse(1'b1, dn_prev[i], dn_q[i], dn_an[i], dn_tc[i]);

        // Load in the tick cycle: q4 goes 1 -> 2 with no extra increment.
        en4 = 1'b1;
        @(negedge clk);
        check_val("ld_tick_pre", q4, 1);
        load4 = 1'b1; dato4 = 2'd2;
        @(negedge clk);
        load4 = 1'b0;
        check_val("ld_tick_q", q4, 2);
        check_val("ld_tick_an", an4, 4'b1011);
        check_val("ld_tick_tc", tc4, 0);
        repeat (3) @(negedge clk);
        check_val("ld_tick_hold", q4, 2);
        en4 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("ld_tick_after", q4, 2);

        load3 = 1'b1; dato3 = 2'd3;
        @(negedge clk);
        check_val("ld_oor_q3", q3, 0);
        check_val("ld_oor_an3", an3, 3'b110);
        dato3 = 2'd1;
        @(negedge clk);
        load3 = 1'b0;
        check_val("ld_ok_q3", q3, 1);
        check_val("ld_ok_an3", an3, 3'b101);

        en4 = 1'b1;
        repeat (2) @(negedge clk);
        check_val("held_first", q4, 3);
        repeat (18) @(negedge clk);
        check_val("held_end", q4, 3);
        check_val("held_tc", tc4, 0);
        en4 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("held_after", q4, 3);

        // Reset while a down tick is pending: 3 -> 0, never 3 -> 2.
        dir4 = 1'b0;
        en4 = 1'b1;
        @(negedge clk);
        check_val("rstmid_pre", q4, 3);
        rst = 1'b0; en4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_val("rstmid_q4", q4, 0);
        check_val("rstmid_an4", an4, 4'b1110);
        check_val("rstmid_tc4", tc4, 0);
        check_val("rstmid_q3", q3, 0);
        check_val("rstmid_an3", an3, 3'b110);
        @(negedge clk);
        check_val("rstmid_next", q4, 0);
        @(negedge clk);
        check_val("rstmid_next2", q4, 0);
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
